// File: rtl/posit_pkg.sv
// Package shared by the posit decode, accumulate and encode stages.
// Derives the accumulator geometry from the posit format and provides the
// round-to-nearest-even decision used when a posit is narrowed.
package posit_pkg;

  // Fixed-point fraction bits of the accumulator: 2^(es+1) * (width-2).
  function automatic int calc_bias(input int width, input int es);
    return (1 << (es + 1)) * (width - 2);
  endfunction

  // Guard bits for summing k products (ceil log2).
  function automatic int calc_wk(input int k);
    int r = 0;
    while ((1 << r) < k) r++;
    return r;
  endfunction

  function automatic int calc_width_a(input int wk, input int bias);
    return wk + 2 * bias + 2;
  endfunction

  // Largest representable scale factor (maxpos = useed^(width-2)).
  function automatic int calc_sf_max(input int width, input int es);
    return (width - 2) * (1 << es);
  endfunction

  // Round up when guard is set and either something below it is set or the
  // kept LSB is odd (ties go to even).
  function automatic logic rne_round(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/posit_lod.sv
// Leading-one detector.
//   value : input word
//   pos   : bit index of the most significant set bit (0 when value is 0)
//   zero  : value is all zeros
module posit_lod #(
  parameter int W = 8
) (
  input  logic [W-1:0]         value,
  output logic [$clog2(W)-1:0] pos,
  output logic                 zero
);

  localparam int PW = $clog2(W);

  always_comb begin
    pos  = '0;
    zero = 1'b1;
    // Ascending scan: the last hit is the highest set bit.
    for (int unsigned i = 0; i < W; i++) begin
      if (value[i]) begin
        pos  = PW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/posit_encode_acc.sv
// Encodes the signed fixed-point accumulator sum (LSB weight 2^-BIAS) into a
// WIDTH-bit posit (es = EXP), round-to-nearest-even with saturation to
// maxpos/minpos. Conversion starts on a rising edge of acc_rdy_i and the
// result is offered on a valid/ready output.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous reset, active high
//   acc_rdy_i : accumulator sum final (level; rising edge starts a conversion)
//   acc_i     : signed accumulator sum
//   posit_o   : encoded posit
//   vld_o     : posit_o valid, held until accepted
//   rdy_i     : downstream accept
//   busy_o    : conversion in flight or result not yet accepted
//   err_o     : sticky, a start arrived while busy and was dropped
module posit_encode_acc
  import posit_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int EXP     = 2,
  parameter int K       = 9,
  parameter int BIAS    = calc_bias(WIDTH, EXP),
  parameter int WK      = calc_wk(K),
  parameter int WIDTH_A = calc_width_a(WK, BIAS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               acc_rdy_i,
  input  logic [WIDTH_A-1:0] acc_i,
  output logic [WIDTH-1:0]   posit_o,
  output logic               vld_o,
  input  logic               rdy_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int PW     = $clog2(WIDTH_A);
  localparam int SFW    = PW + 1;
  localparam int SF_MAX = calc_sf_max(WIDTH, EXP);
  localparam int SF_MIN = -SF_MAX;
  localparam int MW     = WIDTH_A - 1;
  // Regime prefix + exponent + mantissa + room for the largest regime shift.
  localparam int BW     = 2 + EXP + MW + (WIDTH - 2);
  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINPOS = WIDTH'(1);

  // ---------------------------------------------------------------- control
  logic acc_rdy_q;
  logic start, accept_out, take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_rdy_q <= 1'b1;  // a level already high at release is not a start
    else       acc_rdy_q <= acc_rdy_i;
  end

  assign start      = acc_rdy_i & ~acc_rdy_q;
  assign accept_out = vld_o & rdy_i;
  // The result leaving on this edge frees the pipe for a start on the same edge.
  assign take       = start & (~busy_o | accept_out);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (take)            busy_o <= 1'b1;
      else if (accept_out) busy_o <= 1'b0;
      if (start && !take)  err_o  <= 1'b1;
    end
  end

  // --------------------------------------------------------- S0: magnitude
  logic               s0_vld, s0_sign;
  logic [WIDTH_A-1:0] s0_abs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_vld  <= 1'b0;
      s0_sign <= 1'b0;
      s0_abs  <= '0;
    end else begin
      s0_vld <= take;
      if (take) begin
        s0_sign <= acc_i[WIDTH_A-1];
        s0_abs  <= acc_i[WIDTH_A-1] ? (~acc_i + WIDTH_A'(1)) : acc_i;
      end
    end
  end

  // ------------------------------------------------ S1: leading one, align
  logic [PW-1:0] lod_pos;
  logic          lod_zero;
  logic [PW-1:0] lshift;

  posit_lod #(.W(WIDTH_A)) u_lod (
    .value (s0_abs),
    .pos   (lod_pos),
    .zero  (lod_zero)
  );

  assign lshift = PW'(WIDTH_A - 1) - lod_pos;

  logic          s1_vld, s1_sign, s1_zero;
  logic [PW-1:0] s1_pos;
  logic [MW-1:0] s1_mant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_pos  <= '0;
      s1_mant <= '0;
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_sign <= s0_sign;
        s1_zero <= lod_zero;
        s1_pos  <= lod_pos;
        // Leading one lands on the dropped MSB: keeps only the fraction.
        s1_mant <= MW'(s0_abs << lshift);
      end
    end
  end

  // ------------------------------------------------------ S2: scale factor
  logic                  s2_vld, s2_sign, s2_zero;
  logic signed [SFW-1:0] s2_sf;
  logic [MW-1:0]         s2_mant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_sf   <= '0;
      s2_mant <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_sf   <= $signed({1'b0, s1_pos}) - SFW'(BIAS);
        s2_mant <= s1_mant;
      end
    end
  end

  // ------------------------------------------------------------ encode
  logic signed [SFW-1:0] k;
  logic [SFW-1:0]        shamt;
  logic [1:0]            prefix;
  logic signed [BW-1:0]  rbuf, shifted;
  logic [WIDTH-2:0]      body;
  logic                  guard, sticky;
  logic [WIDTH-1:0]      rnd, mag, enc;

  always_comb begin
    k = s2_sf >>> EXP;
    // Regime built by arithmetic shift: "10" smeared right by k gives k+1 ones
    // then 0; "01" shifted by -k-1 (= ~k) gives -k zeros then 1.
    if (k[SFW-1]) begin
      prefix = 2'b01;
      shamt  = ~k;
    end else begin
      prefix = 2'b10;
      shamt  = k;
    end
    rbuf    = {prefix, s2_sf[EXP-1:0], s2_mant, {(WIDTH-2){1'b0}}};
    shifted = rbuf >>> shamt;
    body    = shifted[BW-1 -: WIDTH-1];
    guard   = shifted[BW-WIDTH];
    sticky  = |shifted[BW-WIDTH-1:0];
    rnd     = {1'b0, body} + WIDTH'(rne_round(body[0], guard, sticky));
    if (int'(s2_sf) > SF_MAX || rnd[WIDTH-1])  mag = MAXPOS;
    else if (int'(s2_sf) < SF_MIN || rnd == '0) mag = MINPOS;
    else                                        mag = rnd;
    if (s2_zero)      enc = '0;
    else if (s2_sign) enc = -mag;
    else              enc = mag;
  end

  // ------------------------------------------------------- output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_o   <= 1'b0;
      posit_o <= '0;
    end else if (s2_vld) begin
      vld_o   <= 1'b1;
      posit_o <= enc;
    end else if (accept_out) begin
      vld_o   <= 1'b0;
    end
  end

endmodule
